// File: rtl/sqlite_row_reader_if.sv
// rtl/sqlite_row_reader_if.sv - stream bundle between the row reader, its command source, cell bridge and row consumer
//
// Purpose: groups every handshake and status signal of sqlite_row_reader so the
// reader and its environment connect through one port.
//   cmd_*  : command stream (first row id, row count) into the reader
//   req_*  : cell request stream from the reader to the bridge
//   rsp_*  : cell response strobe from the bridge (no backpressure)
//   row_*  : assembled row stream from the reader to the consumer
//   busy/done/err/err_code : reader status
// Modports: master = environment side, slave = reader side.

interface sqlite_row_reader_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_COLS = 4,
  parameter int ROWID_W  = 32,
  parameter int CNT_W    = 16
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [ROWID_W-1:0]         cmd_first_rowid;
  logic [CNT_W-1:0]           cmd_row_count;
  logic                       req_valid;
  logic                       req_ready;
  logic [ROWID_W-1:0]         req_rowid;
  logic [3:0]                 req_col;
  logic                       rsp_valid;
  logic [DATA_W-1:0]          rsp_data;
  logic                       rsp_status;
  logic                       row_valid;
  logic                       row_ready;
  logic [NUM_COLS*DATA_W-1:0] row_data;
  logic [ROWID_W-1:0]         row_id;
  logic                       row_last;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [1:0]                 err_code;

  modport master (
    output cmd_valid, cmd_first_rowid, cmd_row_count, req_ready,
           rsp_valid, rsp_data, rsp_status, row_ready,
    input  cmd_ready, req_valid, req_rowid, req_col,
           row_valid, row_data, row_id, row_last,
           busy, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_first_rowid, cmd_row_count, req_ready,
           rsp_valid, rsp_data, rsp_status, row_ready,
    output cmd_ready, req_valid, req_rowid, req_col,
           row_valid, row_data, row_id, row_last,
           busy, done, err, err_code
  );
endinterface

// File: rtl/sqlite_row_reader.sv
// rtl/sqlite_row_reader.sv - walks a range of stored rows, fetches each cell from the bridge and streams whole rows
//
// Purpose: accepts (first row id, row count), requests NUM_COLS cells per row
// from the simulation bridge, packs them into one row word and presents it on
// a valid/ready stream. A not-found response or a response timeout aborts the
// command with a sticky error; the partially fetched row is dropped.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (aborts immediately, no done pulse)
//   bus  : sqlite_row_reader_if.slave (cmd/req/rsp/row streams and status)

module sqlite_row_reader #(
  parameter int DATA_W         = 64,
  parameter int NUM_COLS       = 4,
  parameter int ROWID_W        = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  sqlite_row_reader_if.slave  bus
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_FIN} state_t;

  state_t                     state_q, state_d;
  logic [ROWID_W-1:0]         rowid_q, rowid_d;
  logic [CNT_W-1:0]           remain_q, remain_d;
  logic [3:0]                 col_q, col_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic [NUM_COLS*DATA_W-1:0] row_q, row_d;
  logic                       err_q, err_d;
  logic [1:0]                 code_q, code_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rowid_q  <= '0;
      remain_q <= '0;
      col_q    <= '0;
      tmo_q    <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      rowid_q  <= rowid_d;
      remain_q <= remain_d;
      col_q    <= col_d;
      tmo_q    <= tmo_d;
      row_q    <= row_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rowid_d  = rowid_q;
    remain_d = remain_q;
    col_d    = col_q;
    tmo_d    = tmo_q;
    row_d    = row_q;
    err_d    = err_q;
    code_d   = code_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          rowid_d  = bus.cmd_first_rowid;
          remain_d = bus.cmd_row_count;
          col_d    = '0;
          err_d    = 1'b0;
          code_d   = 2'd0;
          state_d  = (bus.cmd_row_count == '0) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.req_ready) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the expiry cycle is still taken: rsp_valid is checked first.
        if (bus.rsp_valid) begin
          if (bus.rsp_status) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_FIN;
          end else begin
            row_d[32'(col_q) * DATA_W +: DATA_W] = bus.rsp_data;
            if (col_q < 4'(NUM_COLS - 1)) begin
              col_d   = col_q + 4'd1;
              state_d = S_REQ;
            end else begin
              state_d = S_EMIT;
            end
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_EMIT: begin
        if (bus.row_ready) begin
          remain_d = remain_q - CNT_W'(1);
          rowid_d  = rowid_q + ROWID_W'(1);  // wraps naturally at 2^ROWID_W
          col_d    = '0;
          state_d  = (remain_q == CNT_W'(1)) ? S_FIN : S_REQ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE);
    bus.busy      = (state_q != S_IDLE);
    bus.req_valid = (state_q == S_REQ);
    bus.row_valid = (state_q == S_EMIT);
    bus.row_last  = (state_q == S_EMIT) && (remain_q == CNT_W'(1));
    bus.done      = (state_q == S_FIN);
  end

  // Request and row fields come straight from registers, so they cannot move
  // while a handshake is pending.
  assign bus.req_rowid = rowid_q;
  assign bus.req_col   = col_q;
  assign bus.row_id    = rowid_q;
  assign bus.row_data  = row_q;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;
endmodule

// File: tb/tb_sqlite_row_reader.sv
// tb/tb_sqlite_row_reader.sv - directed self-checking bench for sqlite_row_reader
module tb_sqlite_row_reader;
  localparam int DATA_W   = 64;
  localparam int NUM_COLS = 4;
  localparam int ROWID_W  = 32;
  localparam int CNT_W    = 16;
  localparam int TMO      = 1024;
  localparam int RW       = NUM_COLS * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   t0;
  int   n;

  sqlite_row_reader_if #(.DATA_W(DATA_W), .NUM_COLS(NUM_COLS), .ROWID_W(ROWID_W), .CNT_W(CNT_W)) bus ();

  sqlite_row_reader #(
    .DATA_W(DATA_W), .NUM_COLS(NUM_COLS), .ROWID_W(ROWID_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_row_valid", bus.row_valid, 0);
    chk("rst_row_last", bus.row_last, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_row_data", bus.row_data, 0);
    chk("rst_row_id", bus.row_id, 0);
    chk("rst_req_rowid", bus.req_rowid, 0);
    chk("rst_req_col", bus.req_col, 0);
  endtask

  // Called on a negedge; returns on the negedge after the accept edge.
  task automatic send_cmd(input logic [31:0] first, input logic [15:0] count);
    chk("cmd_ready_before", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_first_rowid = first;
    bus.cmd_row_count = count;
    t0 = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!bus.req_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Bridge for one cell: accepts the request after 'hold' stalled cycles and
  // answers on the cycle after the handshake with data = rowid*16 + col.
  task automatic serve_cell(input logic [31:0] rid, input logic [3:0] col, input logic st, input int hold);
    wait_req();
    chk("req_valid", bus.req_valid, 1);
    chk("req_rowid", bus.req_rowid, rid);
    chk("req_col", bus.req_col, col);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("req_hold_valid", bus.req_valid, 1);
      chk("req_hold_rowid", bus.req_rowid, rid);
      chk("req_hold_col", bus.req_col, col);
    end
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b1;
    bus.rsp_data = {28'b0, rid, col};
    bus.rsp_status = st;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_status = 1'b0;
  endtask

  task automatic serve_row(input logic [31:0] rid);
    for (int c = 0; c < NUM_COLS; c++) serve_cell(rid, 4'(c), 1'b0, 0);
  endtask

  task automatic take_row(input logic [31:0] id, input logic [RW-1:0] data, input logic last, input int stall);
    int k = 0;
    while (!bus.row_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("row_valid", bus.row_valid, 1);
    chk("row_id", bus.row_id, id);
    chk("row_data", bus.row_data, data);
    chk("row_last", bus.row_last, last);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("row_hold_valid", bus.row_valid, 1);
      chk("row_hold_id", bus.row_id, id);
      chk("row_hold_data", bus.row_data, data);
      chk("row_hold_last", bus.row_last, last);
    end
    bus.row_ready = 1'b1;
    @(negedge clk);
    bus.row_ready = 1'b0;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_first_rowid = '0;
    bus.cmd_row_count = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data = '0;
    bus.rsp_status = 1'b0;
    bus.row_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Three rows from id 5, zero-wait bridge.
    send_cmd(32'd5, 16'd3);
    chk("busy_after_accept", bus.busy, 1);
    serve_row(32'd5);
    chk("first_row_latency", cyc - t0, 9);
    take_row(32'd5, {64'h53, 64'h52, 64'h51, 64'h50}, 1'b0, 0);
    serve_row(32'd6);
    take_row(32'd6, {64'h63, 64'h62, 64'h61, 64'h60}, 1'b0, 0);
    serve_row(32'd7);
    take_row(32'd7, {64'h73, 64'h72, 64'h71, 64'h70}, 1'b1, 0);
    chk("t1_done", bus.done, 1);
    chk("t1_err", bus.err, 0);
    @(negedge clk);
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_idle", bus.busy, 0);

    // Zero-count command.
    send_cmd(32'd9, 16'd0);
    chk("c0_done", bus.done, 1);
    chk("c0_done_latency", cyc - t0, 1);
    chk("c0_no_req", bus.req_valid, 0);
    chk("c0_cmd_ready_fin", bus.cmd_ready, 0);
    @(negedge clk);
    chk("c0_done_pulse", bus.done, 0);
    chk("c0_busy", bus.busy, 0);
    chk("c0_no_req_idle", bus.req_valid, 0);

    // Not-found on row 11 col 2.
    send_cmd(32'd10, 16'd2);
    serve_row(32'd10);
    take_row(32'd10, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 1'b0, 0);
    serve_cell(32'd11, 4'd0, 1'b0, 0);
    serve_cell(32'd11, 4'd1, 1'b0, 0);
    serve_cell(32'd11, 4'd2, 1'b1, 0);
    chk("nf_done", bus.done, 1);
    chk("nf_err", bus.err, 1);
    chk("nf_err_code", bus.err_code, 1);
    chk("nf_no_row", bus.row_valid, 0);
    @(negedge clk);
    chk("nf_no_row_idle", bus.row_valid, 0);
    chk("nf_err_sticky", bus.err, 1);
    chk("nf_busy", bus.busy, 0);
    send_cmd(32'd0, 16'd0);
    chk("nf_err_cleared", bus.err, 0);
    chk("nf_code_cleared", bus.err_code, 0);
    @(negedge clk);

    // Bridge never answers.
    send_cmd(32'd100, 16'd1);
    wait_req();
    chk("tmo_req", bus.req_valid, 1);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    t0 = cyc;
    n = 0;
    while (!bus.done && n < 1200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_done", bus.done, 1);
    chk("tmo_latency", cyc - t0, TMO);
    chk("tmo_err", bus.err, 1);
    chk("tmo_err_code", bus.err_code, 2);
    chk("tmo_no_row", bus.row_valid, 0);
    @(negedge clk);
    bus.rsp_valid = 1'b1;
    bus.rsp_status = 1'b1;
    bus.rsp_data = 64'hDEAD;
    @(negedge clk);
    bus.rsp_valid = 1'b0;
    bus.rsp_status = 1'b0;
    chk("spur_err_code", bus.err_code, 2);
    chk("spur_busy", bus.busy, 0);
    chk("spur_cmd_ready", bus.cmd_ready, 1);
    chk("spur_done", bus.done, 0);

    // Backpressure on both the request and the row stream.
    send_cmd(32'd20, 16'd1);
    serve_cell(32'd20, 4'd0, 1'b0, 0);
    serve_cell(32'd20, 4'd1, 1'b0, 3);
    serve_cell(32'd20, 4'd2, 1'b0, 0);
    serve_cell(32'd20, 4'd3, 1'b0, 0);
    take_row(32'd20, {64'h143, 64'h142, 64'h141, 64'h140}, 1'b1, 5);
    chk("bp_done", bus.done, 1);
    @(negedge clk);

    // Row id wrap, then reset in the middle of the second row.
    send_cmd(32'hFFFF_FFFF, 16'd2);
    serve_row(32'hFFFF_FFFF);
    take_row(32'hFFFF_FFFF, {64'hF_FFFF_FFF3, 64'hF_FFFF_FFF2, 64'hF_FFFF_FFF1, 64'hF_FFFF_FFF0}, 1'b0, 0);
    wait_req();
    chk("wrap_req_rowid", bus.req_rowid, 0);
    chk("wrap_req_col", bus.req_col, 0);
    bus.req_ready = 1'b1;
    @(negedge clk);
    bus.req_ready = 1'b0;
    chk("wrap_in_wait", bus.req_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_done", bus.done, 0);
    @(negedge clk);
    chk("mid_rst_no_done2", bus.done, 0);
    send_cmd(32'd3, 16'd1);
    serve_row(32'd3);
    take_row(32'd3, {64'h33, 64'h32, 64'h31, 64'h30}, 1'b1, 0);
    chk("post_rst_done", bus.done, 1);
    @(negedge clk);
    chk("post_rst_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
